ushift_ser_ctrl: RTL and testbench
==================================

Name: ushift_ser_ctrl

Overview:
- Upstream sequencer for the 4-bit universal shift register ushift_4; turns it into a parallel-to-serial transmitter.
- Accepts a word over a valid/ready handshake and drives the register's sel, i_par, msb_in and lsb_in.
- Reads back a_par and presents one serial bit per cycle with a strobe, LSB-first or MSB-first.

Parameters:
- WIDTH, 4: word/shift-register width; bit counter is $clog2(WIDTH) bits.

Ports:
- clk  in  1  rising-edge clock
- clear_b  in  1  reset, asynchronous, active-low
- data_in  in  WIDTH  word to serialize
- data_valid  in  1  data_in valid
- dir  in  1  0 = LSB-first (shift right), 1 = MSB-first (shift left); sampled with data
- fill_bit  in  1  value shifted into vacated end
- a_par  in  WIDTH  shift-register parallel output
- data_ready  out  1  controller idle, can accept
- sel  out  2  to register: 00 hold, 01 shift right, 10 shift left, 11 load
- i_par  out  WIDTH  to register parallel input
- msb_in  out  1  to register
- lsb_in  out  1  to register
- ser_out  out  1  serial bit
- ser_valid  out  1  ser_out valid this cycle
- done  out  1  one-cycle end-of-frame pulse

Behaviour:
- Clock and reset: one clock, clk. clear_b is asynchronous, active-low; all state clears immediately when it falls.
- Reset state:
  - state=IDLE, cnt=0, dir_q=0, word_q=0.
  - sel=00, i_par=0, msb_in=lsb_in=0, ser_out=0, ser_valid=0, done=0.
  - data_ready=1 (Moore output of IDLE).
- Output style: all outputs are Moore functions of registered state; no combinational path from data_valid to any output.
- IDLE:
  - data_ready=1, sel=00.
  - Handshake fires at an edge where data_valid & data_ready: capture word_q<=data_in, dir_q<=dir, go to LOAD.
- LOAD (1 cycle):
  - sel=11, i_par=word_q, data_ready=0.
  - Register loads at the closing edge; go to SHIFT, cnt<=0.
- SHIFT (WIDTH cycles):
  - sel = dir_q ? 10 : 01.
  - msb_in=lsb_in=fill_bit.
  - ser_valid=1, ser_out = dir_q ? a_par[WIDTH-1] : a_par[0].
  - cnt increments each edge. At the edge with cnt==WIDTH-1, go to DONE, cnt<=0.
- DONE (1 cycle):
  - sel=00, done=1, ser_valid=0.
  - Next state IDLE.
- Frame timing:
  - Latency from handshake edge to first ser_valid: 2 cycles.
  - Frame length: WIDTH+2 cycles (6 for WIDTH=4).
  - Next handshake is possible in the cycle after DONE.
- Outside SHIFT: ser_out=0. i_par=0 outside LOAD.
- Boundary rules:
  - data_valid while data_ready=0 is ignored; the word is not queued.
  - data_in and dir changes after capture have no effect on the current frame.
  - Reset mid-frame aborts the frame: no done pulse; the register sees sel=00 immediately.
  - The register's own contents are the register's responsibility (shared clear_b).
  - cnt never exceeds WIDTH-1; no wrap-around.

Optional Feature:
- Macro: USHIFT_SER_CTRL_PARITY_EN.
- Defined: adds a PARITY state between SHIFT and DONE.
  - PARITY: sel=00, ser_valid=1, ser_out = ^word_q (even parity).
  - Frame becomes WIDTH+3 cycles.
- Undefined: no PARITY state and no parity logic; SHIFT goes directly to DONE.

Decomposition:
- Package ushift_pkg:
  - Select codes SEL_HOLD=2'b00, SEL_SHR=2'b01, SEL_SHL=2'b10, SEL_LOAD=2'b11.
  - State encodings ST_IDLE, ST_LOAD, ST_SHIFT, ST_PARITY, ST_DONE.
  - Shared with any future serial receiver.
- One sub-module: ushift_bit_cnt.
  - Parameterised modulo-WIDTH up-counter with enable, synchronous clear and terminal-count flag.
  - Async active-low reset on clear_b.
  - FSM stays in the top module.

Test Plan:
- Bench instantiates ushift_ser_ctrl connected to ushift_4 with a 10-unit clock.
- LSB-first: data_in=1101, dir=0, fill_bit=0, one-cycle valid -> ser_out 1,0,1,1 with ser_valid high for 4 cycles starting 2 cycles after accept; done 1 cycle later; a_par ends 0000.
- MSB-first: data_in=1101, dir=1, fill_bit=1 -> ser_out 1,1,0,1; a_par ends 1111; data_ready low for exactly 6 cycles.
- Back-to-back: data_valid held high with 1001 then 0110 (dir=0) -> frames 1,0,0,1 then 0,1,1,0; second accept in the cycle after done; no word lost or duplicated.
- Busy ignore: change data_in to 0000 and pulse data_valid during SHIFT of 1101 -> current frame unchanged, no extra frame, data_ready stays 0 until after DONE.
- Reset mid-frame: assert clear_b low between clock edges during the 2nd SHIFT cycle -> all outputs go to reset values immediately, no done pulse; after release a fresh 0011 frame serializes correctly.
- Parity build (USHIFT_SER_CTRL_PARITY_EN defined): 1101 dir=0 -> 1,0,1,1 then parity bit 1, frame 7 cycles; data 1001 -> parity bit 0.

Source files
------------

// File: rtl/ushift_ser_ctrl_pkg.sv
// Shared definitions for the ushift_4 sequencers: register select codes
// and controller state encodings, reused by any future serial receiver.
package ushift_pkg;

   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_SHR  = 2'b01;
   localparam logic [1:0] SEL_SHL  = 2'b10;
   localparam logic [1:0] SEL_LOAD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SHIFT  = 3'd2,
      ST_PARITY = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // MSB-first frames shift left so the top bit reaches the serial tap first.
   function automatic logic [1:0] shift_sel(input logic msb_first);
      return msb_first ? SEL_SHL : SEL_SHR;
   endfunction

endpackage

// File: rtl/ushift_ser_ctrl_bit_cnt.sv
// Modulo-WIDTH bit counter with enable, synchronous clear and a
// terminal-count flag marking the last bit position of a frame.
module ushift_bit_cnt #(
   parameter int WIDTH = 4,
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic          clk,
   input  logic          clear_b,
   input  logic          en,
   input  logic          clr,
   output logic [CW-1:0] cnt,
   output logic          tc
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   assign tc = (cnt == LAST);

   // Count enabled cycles, returning to zero after the last position.
   always_ff @(posedge clk or negedge clear_b) begin
      if (!clear_b) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/ushift_ser_ctrl.sv
// Parallel-to-serial sequencer for the ushift_4 universal shift register.
// Loads a captured word into the register, shifts it out one bit per
// cycle (LSB- or MSB-first) and pulses done at the end of each frame.
// Optional: define USHIFT_SER_CTRL_PARITY_EN to append an even-parity bit.
module ushift_ser_ctrl
   import ushift_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clear_b,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   input  logic             dir,
   input  logic             fill_bit,
   input  logic [WIDTH-1:0] a_par,
   output logic             data_ready,
   output logic [1:0]       sel,
   output logic [WIDTH-1:0] i_par,
   output logic             msb_in,
   output logic             lsb_in,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] word_q;
   logic             dir_q;
   logic             last_bit;
   logic [CW-1:0]    cnt_unused;
   logic             unused_a_par;

   // Only the two end taps of the register are observed.
   assign unused_a_par = ^a_par;

   ushift_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
      .clk     (clk),
      .clear_b (clear_b),
      .en      (state == ST_SHIFT),
      .clr     (state == ST_LOAD),
      .cnt     (cnt_unused),
      .tc      (last_bit)
   );

   // State register plus word/direction capture on an accepted handshake.
   always_ff @(posedge clk or negedge clear_b) begin
      if (!clear_b) begin
         state  <= ST_IDLE;
         word_q <= '0;
         dir_q  <= 1'b0;
      end else begin
         state <= state_next;
         if (state == ST_IDLE && data_valid) begin
            word_q <= data_in;
            dir_q  <= dir;
         end
      end
   end

   // Next-state logic and Moore outputs decoded from the current state.
   always_comb begin
      state_next = state;
      data_ready = 1'b0;
      sel        = SEL_HOLD;
      i_par      = '0;
      msb_in     = 1'b0;
      lsb_in     = 1'b0;
      ser_out    = 1'b0;
      ser_valid  = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            data_ready = 1'b1;
            if (data_valid) begin
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            sel        = SEL_LOAD;
            i_par      = word_q;
            state_next = ST_SHIFT;
         end
         ST_SHIFT: begin
            sel       = shift_sel(dir_q);
            msb_in    = fill_bit;
            lsb_in    = fill_bit;
            ser_valid = 1'b1;
            ser_out   = dir_q ? a_par[WIDTH-1] : a_par[0];
            if (last_bit) begin
`ifdef USHIFT_SER_CTRL_PARITY_EN
               state_next = ST_PARITY;
`else
               state_next = ST_DONE;
`endif
            end
         end
`ifdef USHIFT_SER_CTRL_PARITY_EN
         ST_PARITY: begin
            ser_valid  = 1'b1;
            ser_out    = ^word_q;
            state_next = ST_DONE;
         end
`endif
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ushift_ser_ctrl.sv
// Bench for ushift_ser_ctrl driving a behavioural ushift_4 register.
// Expected serial bits and done pulses are queued at each handshake the
// bench predicts and popped as the controller produces them.
module tb_ushift_ser_ctrl;

   localparam int W = 4;
`ifdef USHIFT_SER_CTRL_PARITY_EN
   localparam int FRAME = W + 3;
   localparam bit PAR   = 1'b1;
`else
   localparam int FRAME = W + 2;
   localparam bit PAR   = 1'b0;
`endif

   typedef struct {
      logic val;
      int   due;
   } exp_bit_t;

   typedef struct {
      int           due;
      logic [W-1:0] apar;
   } exp_done_t;

   logic         clk;
   logic         clear_b;
   logic [W-1:0] data_in;
   logic         data_valid;
   logic         dir;
   logic         fill_bit;
   logic [W-1:0] a_par;
   logic         data_ready;
   logic [1:0]   sel;
   logic [W-1:0] i_par;
   logic         msb_in;
   logic         lsb_in;
   logic         ser_out;
   logic         ser_valid;
   logic         done;

   exp_bit_t  exp_bits[$];
   exp_done_t exp_dones[$];
   int checks;
   int errors;
   int cyc;
   int busy_until;
   int accept_count;

   ushift_ser_ctrl #(.WIDTH(W)) dut (
      .clk        (clk),
      .clear_b    (clear_b),
      .data_in    (data_in),
      .data_valid (data_valid),
      .dir        (dir),
      .fill_bit   (fill_bit),
      .a_par      (a_par),
      .data_ready (data_ready),
      .sel        (sel),
      .i_par      (i_par),
      .msb_in     (msb_in),
      .lsb_in     (lsb_in),
      .ser_out    (ser_out),
      .ser_valid  (ser_valid),
      .done       (done)
   );

   // 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ushift_4: hold, shift right, shift left, parallel load.
   always @(posedge clk or negedge clear_b) begin
      if (!clear_b) begin
         a_par <= '0;
      end else begin
         case (sel)
            2'b01:   a_par <= {msb_in, a_par[W-1:1]};
            2'b10:   a_par <= {a_par[W-2:0], lsb_in};
            2'b11:   a_par <= i_par;
            default: a_par <= a_par;
         endcase
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at cycle %0d", tag, observed, expected, cyc);
      end
   endtask

   // Predict handshakes from the bench's own busy window and queue the frame.
   always @(posedge clk) begin
      exp_bit_t  eb;
      exp_done_t ed;
      int        k;
      if (clear_b && data_valid && cyc >= busy_until) begin
         k = cyc + 1;
         busy_until = k + FRAME;
         accept_count++;
         for (int i = 0; i < W; i++) begin
            eb.val = dir ? data_in[W-1-i] : data_in[i];
            eb.due = k + 1 + i;
            exp_bits.push_back(eb);
         end
         if (PAR) begin
            eb.val = ^data_in;
            eb.due = k + 1 + W;
            exp_bits.push_back(eb);
         end
         ed.due  = k + FRAME - 1;
         ed.apar = fill_bit ? '1 : '0;
         exp_dones.push_back(ed);
      end
      cyc = cyc + 1;
   end

   // A reset aborts any frame in flight: nothing more is expected from it.
   always @(negedge clear_b) begin
      exp_bits.delete();
      exp_dones.delete();
      busy_until = cyc;
   end

   // Compare DUT outputs against the scoreboard on the falling edge.
   always @(negedge clk) begin
      exp_bit_t  eb;
      exp_done_t ed;
      checkOutput("ready", {31'd0, data_ready}, {31'd0, (cyc >= busy_until)});
      if (ser_valid) begin
         if (exp_bits.size() == 0) begin
            checkOutput("unexpBit", 32'd1, 32'd0);
         end else begin
            eb = exp_bits.pop_front();
            checkOutput("bitVal", {31'd0, ser_out}, {31'd0, eb.val});
            checkOutput("bitCycle", cyc, eb.due);
         end
      end else begin
         checkOutput("serIdle", {31'd0, ser_out}, 32'd0);
         if (exp_bits.size() > 0 && exp_bits[0].due <= cyc) begin
            checkOutput("missedBit", 32'd0, 32'd1);
            void'(exp_bits.pop_front());
         end
      end
      if (done) begin
         checkOutput("doneSerValid", {31'd0, ser_valid}, 32'd0);
         if (exp_dones.size() == 0) begin
            checkOutput("unexpDone", 32'd1, 32'd0);
         end else begin
            ed = exp_dones.pop_front();
            checkOutput("doneCycle", cyc, ed.due);
            checkOutput("aParEnd", {28'd0, a_par}, {28'd0, ed.apar});
         end
      end else if (exp_dones.size() > 0 && exp_dones[0].due <= cyc) begin
         checkOutput("missedDone", 32'd0, 32'd1);
         void'(exp_dones.pop_front());
      end
   end

   // Present a word and wait (bounded) until the bench predicts its acceptance.
   task automatic applyStimulus(input logic [W-1:0] word, input logic d, input logic f, input bit keep);
      int start;
      int budget;
      start      = accept_count;
      data_in    = word;
      dir        = d;
      fill_bit   = f;
      data_valid = 1'b1;
      budget     = 0;
      while (accept_count == start && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      if (accept_count == start) checkOutput("acceptTimeout", 32'd0, 32'd1);
      if (!keep) data_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int budget;
      budget = 0;
      while ((exp_bits.size() + exp_dones.size()) > 0 && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      if ((exp_bits.size() + exp_dones.size()) > 0) checkOutput("drainTimeout", 32'd0, 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "Ready"}, {31'd0, data_ready}, 32'd1);
      checkOutput({tag, "Sel"}, {30'd0, sel}, 32'd0);
      checkOutput({tag, "IPar"}, {28'd0, i_par}, 32'd0);
      checkOutput({tag, "FillIn"}, {30'd0, msb_in, lsb_in}, 32'd0);
      checkOutput({tag, "SerOut"}, {31'd0, ser_out}, 32'd0);
      checkOutput({tag, "SerValid"}, {31'd0, ser_valid}, 32'd0);
      checkOutput({tag, "Done"}, {31'd0, done}, 32'd0);
      checkOutput({tag, "APar"}, {28'd0, a_par}, 32'd0);
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks       = 0;
      errors       = 0;
      cyc          = 0;
      busy_until   = 0;
      accept_count = 0;
      clear_b      = 1'b0;
      data_in      = '0;
      data_valid   = 1'b0;
      dir          = 1'b0;
      fill_bit     = 1'b0;
      #3;
      checkResetOutputs("rst");
      @(negedge clk);
      #1 clear_b = 1'b1;
      @(negedge clk);

      $display("[TB] LSB-first 1101");
      applyStimulus(4'b1101, 1'b0, 1'b0, 1'b0);
      waitIdle();

      $display("[TB] MSB-first 1101 fill 1");
      applyStimulus(4'b1101, 1'b1, 1'b1, 1'b0);
      waitIdle();

      $display("[TB] back-to-back 1001 then 0110");
      applyStimulus(4'b1001, 1'b0, 1'b0, 1'b1);
      applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0);
      waitIdle();

      $display("[TB] busy ignore");
      applyStimulus(4'b1101, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      data_in    = 4'b0000;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      waitIdle();
      repeat (4) @(negedge clk);

      $display("[TB] reset mid-frame");
      applyStimulus(4'b1101, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #2 clear_b = 1'b0;
      #1;
      checkResetOutputs("abort");
      @(negedge clk);
      @(negedge clk);
      #1 clear_b = 1'b1;
      @(negedge clk);
      applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0);
      waitIdle();

      checkOutput("queueEmpty", exp_bits.size() + exp_dones.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
